// File: rtl/ntt_sched_pkg.sv
// Shared definitions for the NTT job scheduler.
//   sched_state_e : scheduler FSM states
//   owner_t       : index of the requester that owns the core
//   calc_addrw()  : core address width derived from log2 of polynomial length
package ntt_sched_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StRun,
    StCool
  } sched_state_e;

  localparam int unsigned OwnerW = 1;
  typedef logic [OwnerW-1:0] owner_t;

  // The core addresses at least 512 words, plus one bank-select bit.
  function automatic int unsigned calc_addrw(input int unsigned logn);
    return ((logn < 9) ? 9 : logn) + 1;
  endfunction

endpackage

// File: rtl/ntt_job_scheduler_if.sv
// Bundle between the scheduler, the two polynomial-memory clients and the NTT core.
//   master : scheduler view (drives grant/done/err/busy, memory and core control)
//   slave  : environment view (requesters, memories and core)
interface ntt_job_scheduler_if
  import ntt_sched_pkg::*;
#(
  parameter int unsigned LOGQ  = 64,
  parameter int unsigned ADDRW = calc_addrw(12)
);
  // Requester side
  logic [1:0]        req;
  logic [1:0]        req_intt;
  logic [2*LOGQ-1:0] req_q;
  logic [1:0]        grant;
  logic [1:0]        done;
  logic [1:0]        err;
  logic              busy;
  // Polynomial memories
  logic [ADDRW-1:0]  mem_read_address;
  logic [2*LOGQ-1:0] mem_read_data;
  logic [ADDRW-1:0]  mem_write_address;
  logic [LOGQ-1:0]   mem_write_data;
  logic [1:0]        mem_wea;
  // NTT core
  logic              core_start;
  logic              core_intt;
  logic [LOGQ-1:0]   core_q;
  logic [LOGQ-1:0]   core_data_in;
  logic [ADDRW-1:0]  core_read_address;
  logic [ADDRW-1:0]  core_write_address;
  logic              core_wea;
  logic [LOGQ-1:0]   core_data_out;
  logic              core_finish;

  modport master (
    input  req, req_intt, req_q, mem_read_data,
    input  core_read_address, core_write_address, core_wea, core_data_out, core_finish,
    output grant, done, err, busy,
    output mem_read_address, mem_write_address, mem_write_data, mem_wea,
    output core_start, core_intt, core_q, core_data_in
  );

  modport slave (
    output req, req_intt, req_q, mem_read_data,
    output core_read_address, core_write_address, core_wea, core_data_out, core_finish,
    input  grant, done, err, busy,
    input  mem_read_address, mem_write_address, mem_write_data, mem_wea,
    input  core_start, core_intt, core_q, core_data_in
  );

endinterface

// File: rtl/ntt_rr_arbiter.sv
// Two-way round-robin arbiter with a last-served pointer.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   en_i          : arbitration allowed this cycle
//   req_i         : request vector
//   gnt_o         : one-hot winner (zero when disabled or no request)
//   update_o      : a grant was issued; pointer advances to the winner
module ntt_rr_arbiter (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o,
  output logic       update_o
);

  // 1 = requester 1 was served last, so requester 0 is preferred after reset.
  logic last_q, last_d;

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      unique case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
        default: gnt_o = 2'b00;
      endcase
    end
  end

  assign update_o = |gnt_o;
  assign last_d   = update_o ? gnt_o[1] : last_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/ntt_job_scheduler.sv
// Shares one NTT core between two requesters, each owning a polynomial memory.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : requester handshake (req/grant/done/err/busy), memory steering and
//              core control (start/mode/modulus/data/finish)
// A job runs IDLE -> START -> RUN -> COOL -> IDLE. Owner, mode and modulus are
// latched on the grant and stay frozen until the scheduler is idle again.
module ntt_job_scheduler
  import ntt_sched_pkg::*;
#(
  parameter int unsigned LOGQ      = 64,
  parameter int unsigned LOGN      = 12,
  parameter int unsigned ADDRW     = calc_addrw(LOGN),
  parameter int unsigned COOLDOWN  = 2,
  parameter int unsigned TIMEOUT_W = 20
) (
  input logic                 clk,
  input logic                 rst,
  ntt_job_scheduler_if.master bus
);

  localparam int unsigned CoolW = $clog2(COOLDOWN + 1);
  // Last RUN cycle before the watchdog reaches its all-ones maximum.
  localparam logic [TIMEOUT_W-1:0] WdLast = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  sched_state_e         state_q, state_d;
  owner_t               owner_q, owner_d;
  logic                 intt_q, intt_d;
  logic [LOGQ-1:0]      modq_q, modq_d;
  logic                 start_q, start_d;
  logic [1:0]           done_q, done_d;
  logic [1:0]           err_q, err_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic [CoolW-1:0]     cool_q, cool_d;

  logic [1:0] arb_gnt;
  logic       arb_update;
  logic [1:0] wea;

  ntt_rr_arbiter u_arb (
    .clk_i    (clk),
    .rst_ni   (rst),
    .en_i     (state_q == StIdle),
    .req_i    (bus.req),
    .gnt_o    (arb_gnt),
    .update_o (arb_update)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    intt_d  = intt_q;
    modq_d  = modq_q;
    start_d = start_q;
    done_d  = 2'b00;
    err_d   = 2'b00;
    wd_d    = wd_q;
    cool_d  = cool_q;
    unique case (state_q)
      StIdle: begin
        if (arb_update) begin
          state_d = StStart;
          owner_d = owner_t'(arb_gnt == 2'b10);
          intt_d  = arb_gnt[1] ? bus.req_intt[1] : bus.req_intt[0];
          modq_d  = arb_gnt[1] ? bus.req_q[2*LOGQ-1:LOGQ] : bus.req_q[LOGQ-1:0];
        end
      end
      StStart: begin
        state_d = StRun;
        start_d = 1'b1;
        wd_d    = '0;
      end
      StRun: begin
        // Finish takes priority over a coincident watchdog expiry.
        if (bus.core_finish) begin
          state_d         = StCool;
          start_d         = 1'b0;
          done_d[owner_q] = 1'b1;
          wd_d            = '0;
          cool_d          = '0;
        end else if (wd_q == WdLast) begin
          state_d        = StCool;
          start_d        = 1'b0;
          err_d[owner_q] = 1'b1;
          wd_d           = '0;
          cool_d         = '0;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      StCool: begin
        if (cool_q == CoolW'(COOLDOWN - 1)) begin
          state_d = StIdle;
          cool_d  = '0;
        end else begin
          cool_d = cool_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      owner_q <= '0;
      intt_q  <= 1'b0;
      modq_q  <= '0;
      start_q <= 1'b0;
      done_q  <= 2'b00;
      err_q   <= 2'b00;
      wd_q    <= '0;
      cool_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      intt_q  <= intt_d;
      modq_q  <= modq_d;
      start_q <= start_d;
      done_q  <= done_d;
      err_q   <= err_d;
      wd_q    <= wd_d;
      cool_q  <= cool_d;
    end
  end

  // Writes stay open through COOL: the core may retire trailing writes after finish.
  always_comb begin
    wea = 2'b00;
    if (state_q != StIdle) begin
      wea[owner_q] = bus.core_wea;
    end
  end

  assign bus.grant = ((state_q == StStart) || (state_q == StRun)) ?
                     (owner_q[0] ? 2'b10 : 2'b01) : 2'b00;
  assign bus.done  = done_q;
  assign bus.err   = err_q;
  assign bus.busy  = (state_q != StIdle);

  assign bus.core_start = start_q;
  assign bus.core_intt  = intt_q;
  assign bus.core_q     = modq_q;

  assign bus.mem_read_address  = ADDRW'(bus.core_read_address);
  assign bus.core_data_in      = owner_q[0] ? bus.mem_read_data[2*LOGQ-1:LOGQ]
                                            : bus.mem_read_data[LOGQ-1:0];
  assign bus.mem_write_address = bus.core_write_address;
  assign bus.mem_write_data    = bus.core_data_out;
  assign bus.mem_wea           = wea;

endmodule

// File: tb/tb_ntt_job_scheduler.sv
// Self-checking bench for ntt_job_scheduler: job-level reference model (round-robin
// pick, frozen job parameters, expected run length, done/err, cooldown length) plus
// a per-cycle check of the core/memory steering.
module tb_ntt_job_scheduler;
  import ntt_sched_pkg::*;

  localparam int unsigned LOGQ      = 64;
  localparam int unsigned LOGN      = 12;
  localparam int unsigned ADDRW     = calc_addrw(LOGN);
  localparam int unsigned COOLDOWN  = 2;
  localparam int unsigned TIMEOUT_W = 7;
  localparam int          WdLimit   = (1 << TIMEOUT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_srv = 1;
  int last_finish_cyc = -100;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ntt_job_scheduler_if #(.LOGQ(LOGQ), .ADDRW(ADDRW)) bus ();

  ntt_job_scheduler #(
    .LOGQ      (LOGQ),
    .LOGN      (LOGN),
    .ADDRW     (ADDRW),
    .COOLDOWN  (COOLDOWN),
    .TIMEOUT_W (TIMEOUT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Round-robin rule: lone requester wins; with both, the one not served last wins.
  task automatic model_pick(input logic [1:0] r, output int w);
    if (r == 2'b11) w = 1 - last_srv;
    else            w = r[1] ? 1 : 0;
    last_srv = w;
  endtask

  // Drive random core/memory traffic and check the steering of this owner.
  task automatic core_traffic(input int owner, input bit force_wr);
    logic [ADDRW-1:0] ra, wa;
    logic [LOGQ-1:0]  d0, d1, wd;
    logic             we;
    ra = ADDRW'($urandom);
    wa = ADDRW'($urandom);
    d0 = {$urandom, $urandom};
    d1 = {$urandom, $urandom};
    wd = {$urandom, $urandom};
    we = 1'($urandom_range(0, 1));
    if (force_wr) begin
      wa = ADDRW'(5);
      wd = LOGQ'(64'hABCD);
      we = 1'b1;
    end
    bus.core_read_address  = ra;
    bus.mem_read_data      = {d1, d0};
    bus.core_write_address = wa;
    bus.core_data_out      = wd;
    bus.core_wea           = we;
    #1;
    check_eq("mem_read_address", 64'(bus.mem_read_address), 64'(ra));
    check_eq("core_data_in", bus.core_data_in, (owner == 1) ? d1 : d0);
    check_eq("mem_write_address", 64'(bus.mem_write_address), 64'(wa));
    check_eq("mem_write_data", bus.mem_write_data, wd);
    check_eq("mem_wea", 64'(bus.mem_wea), 64'(we ? ((owner == 1) ? 2'b10 : 2'b01) : 2'b00));
  endtask

  // Called just after req was driven in an IDLE cycle; returns in the next IDLE cycle.
  task automatic do_job(input int w, input logic exp_intt, input logic [LOGQ-1:0] exp_q,
                        input int lat, input bit mutate);
    int high, gap, exp_high;
    bit exp_done;
    logic [1:0] own_mask;
    own_mask = (w == 1) ? 2'b10 : 2'b01;
    exp_done = (lat <= WdLimit);
    exp_high = exp_done ? lat : WdLimit;

    @(negedge clk);
    check_eq("grant_start", 64'(bus.grant), 64'(own_mask));
    check_eq("core_start_in_start", 64'(bus.core_start), 64'(0));
    check_eq("busy_start", 64'(bus.busy), 64'(1));
    if (mutate) begin
      bus.req_intt = 2'($urandom);
      bus.req_q    = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 3) == 0) bus.req[w] = 1'b0;
    end
    core_traffic(w, 1'b0);

    high = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!bus.core_start) break;
      high++;
      if (high == 1) begin
        check_eq("finish_to_start_gap", 64'((cyc - last_finish_cyc) >= int'(COOLDOWN + 2)),
                 64'(1));
        check_eq("grant_run", 64'(bus.grant), 64'(own_mask));
        check_eq("core_intt", 64'(bus.core_intt), 64'(exp_intt));
        check_eq("core_q", bus.core_q, exp_q);
      end
      check_eq("no_pulse_in_run", 64'({bus.done, bus.err}), 64'(0));
      bus.core_finish = (high == lat);
      core_traffic(w, 1'b0);
    end

    // First COOL cycle.
    last_finish_cyc = cyc - 1;
    check_eq("core_start_high_cycles", 64'(high), 64'(exp_high));
    check_eq("done_pulse", 64'(bus.done), 64'(exp_done ? own_mask : 2'b00));
    check_eq("err_pulse", 64'(bus.err), 64'(exp_done ? 2'b00 : own_mask));
    check_eq("grant_cool", 64'(bus.grant), 64'(0));
    bus.core_finish = 1'($urandom_range(0, 1));
    core_traffic(w, 1'b1);

    gap = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      gap++;
      if (!bus.busy) break;
      check_eq("pulse_width", 64'({bus.done, bus.err}), 64'(0));
      check_eq("grant_cool", 64'(bus.grant), 64'(0));
      bus.core_finish = 1'($urandom_range(0, 1));
      core_traffic(w, 1'b0);
    end
    check_eq("cooldown_len", 64'(gap), 64'(COOLDOWN));
    check_eq("idle_no_pulse", 64'({bus.done, bus.err}), 64'(0));
    bus.core_finish = 1'b0;
    bus.core_wea    = 1'b1;
    #1;
    check_eq("idle_wea_gated", 64'(bus.mem_wea), 64'(0));
  endtask

  task automatic run(input int lat, input bit mutate);
    int w;
    model_pick(bus.req, w);
    do_job(w, bus.req_intt[w], bus.req_q[w*LOGQ +: LOGQ], lat, mutate);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, sel;
    bus.req = '0;
    bus.req_intt = '0;
    bus.req_q = '0;
    bus.mem_read_data = '0;
    bus.core_read_address = '0;
    bus.core_write_address = '0;
    bus.core_data_out = '0;
    bus.core_wea = 1'b1;
    bus.core_finish = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_grant", 64'(bus.grant), 64'(0));
    check_eq("rst_done", 64'(bus.done), 64'(0));
    check_eq("rst_err", 64'(bus.err), 64'(0));
    check_eq("rst_busy", 64'(bus.busy), 64'(0));
    check_eq("rst_core_start", 64'(bus.core_start), 64'(0));
    check_eq("rst_core_intt", 64'(bus.core_intt), 64'(0));
    check_eq("rst_core_q", bus.core_q, 64'(0));
    check_eq("rst_mem_wea", 64'(bus.mem_wea), 64'(0));
    rst = 1'b1;
    bus.core_finish = 1'b0;
    bus.core_wea = 1'b0;
    @(negedge clk);
    check_eq("idle_busy", 64'(bus.busy), 64'(0));

    // Single forward job, Goldilocks modulus.
    bus.req = 2'b01;
    bus.req_intt = 2'b10;
    bus.req_q = {$urandom, $urandom, 64'hFFFF_FFFF_0000_0001};
    run(101, 1'b0);
    bus.req = 2'b00;
    repeat (3) begin
      @(negedge clk);
      check_eq("idle_gap_busy", 64'(bus.busy), 64'(0));
      check_eq("idle_gap_grant", 64'(bus.grant), 64'(0));
    end

    // Contention with both requests held: grants alternate.
    bus.req = 2'b11;
    bus.req_intt = 2'b10;
    bus.req_q = {$urandom, $urandom, $urandom, $urandom};
    for (int j = 0; j < 4; j++) run($urandom_range(5, 40), 1'b0);

    // Watchdog boundaries: never finish, finish on the last cycle, one cycle too late.
    bus.req = 2'b01;
    run(1000, 1'b0);
    bus.req = 2'b10;
    run(WdLimit, 1'b0);
    bus.req = 2'b01;
    run(WdLimit + 1, 1'b0);
    bus.req = 2'b10;
    run(WdLimit - 1, 1'b0);

    // Reset in the middle of a job.
    bus.req = 2'b01;
    begin
      int w;
      model_pick(bus.req, w);
    end
    @(negedge clk);
    check_eq("rstjob_grant", 64'(bus.grant), 64'(2'b01));
    repeat (10) @(negedge clk);
    check_eq("rstjob_running", 64'(bus.core_start), 64'(1));
    bus.core_wea = 1'b1;
    #2 rst = 1'b0;
    #1;
    check_eq("midrst_core_start", 64'(bus.core_start), 64'(0));
    check_eq("midrst_grant", 64'(bus.grant), 64'(0));
    check_eq("midrst_busy", 64'(bus.busy), 64'(0));
    check_eq("midrst_pulses", 64'({bus.done, bus.err}), 64'(0));
    check_eq("midrst_mem_wea", 64'(bus.mem_wea), 64'(0));
    @(negedge clk);
    check_eq("midrst_pulses_later", 64'({bus.done, bus.err}), 64'(0));
    last_srv = 1;
    bus.core_wea = 1'b0;
    bus.req = 2'b10;
    rst = 1'b1;
    run(20, 1'b0);
    bus.req = 2'b11;
    run(15, 1'b0);

    // Randomized jobs.
    for (int j = 0; j < 16; j++) begin
      if ($urandom_range(0, 2) == 0) begin
        bus.req = 2'b00;
        repeat ($urandom_range(1, 3)) begin
          @(negedge clk);
          check_eq("rand_idle_busy", 64'(bus.busy), 64'(0));
        end
      end
      bus.req = 2'($urandom_range(1, 3));
      bus.req_intt = 2'($urandom);
      bus.req_q = {$urandom, $urandom, $urandom, $urandom};
      sel = $urandom_range(0, 9);
      if (sel == 0)      lat = 1000;
      else if (sel == 1) lat = WdLimit;
      else if (sel == 2) lat = WdLimit + 1;
      else               lat = $urandom_range(1, 60);
      run(lat, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
